// File: rtl/store_queue_if.sv
// Store queue memory drain bus: packet type shared with the resolve path,
// plus the request/ready interface between the queue and data memory.

package store_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] result;
    logic [3:0]  byte_mask;
    logic [4:0]  dest_reg_idx;
  } STORE_QUEUE_PACKET;

endpackage

interface store_queue_if;

  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_byte_mask;
  logic        mem_req_ready;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    output mem_req_data,
    output mem_req_byte_mask,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    input  mem_req_data,
    input  mem_req_byte_mask,
    output mem_req_ready
  );

endinterface

// File: rtl/store_queue.sv
// Store queue: circular buffer of stores allocated at dispatch, resolved by
// the address stage, committed in order by the ROB, and drained to memory
// from the head. A flush discards everything not yet committed.

module store_queue
  import store_queue_pkg::*;
#(
  parameter int SQ_SZ = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic [SQ_SZ-1:0]  sq_alloc_mask,
  output logic              sq_full,
  output logic              sq_empty,
  input  STORE_QUEUE_PACKET sq_packet,
  input  logic [SQ_SZ-1:0]  resolving_sq_mask,
  output logic [SQ_SZ-1:0]  resolved_mask,
  input  logic              store_retire,
  input  logic              flush,
  store_queue_if.master     mem
);

  localparam int PTR_W = $clog2(SQ_SZ);
  localparam int CNT_W = $clog2(SQ_SZ + 1);

  logic [SQ_SZ-1:0] entry_valid;
  logic [SQ_SZ-1:0] entry_resolved;
  logic [SQ_SZ-1:0] entry_committed;
  logic [29:0]      entry_word_addr [SQ_SZ];
  logic [31:0]      entry_result    [SQ_SZ];
  logic [3:0]       entry_byte_mask [SQ_SZ];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] commit_ptr;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             alloc_accept;
  logic             retire_ok;
  logic             pop;
  logic [PTR_W-1:0] commit_next;
  logic [SQ_SZ-1:0] resolve_hit;
  logic [SQ_SZ-1:0] retire_hit;
  logic [CNT_W-1:0] survivors;

  // Only the word address is kept, and the destination tag is not needed
  // once the store is in the queue.
  logic unused_packet_bits;
  assign unused_packet_bits = ^{sq_packet.dest_reg_idx, sq_packet.addr[1:0]};

  assign sq_full       = (count == CNT_W'(SQ_SZ));
  assign sq_empty      = (count == '0);
  assign sq_alloc_mask = {{(SQ_SZ-1){1'b0}}, 1'b1} << tail;
  assign resolved_mask = entry_valid & entry_resolved;

  assign mem.mem_req_valid     = entry_valid[head] & entry_committed[head] & entry_resolved[head];
  assign mem.mem_req_addr      = {entry_word_addr[head], 2'b00};
  assign mem.mem_req_data      = entry_result[head];
  assign mem.mem_req_byte_mask = entry_byte_mask[head];

  assign alloc_accept = alloc_valid && !sq_full;
  assign pop          = mem.mem_req_valid && mem.mem_req_ready;
  assign retire_ok    = store_retire && entry_valid[commit_ptr] &&
                        entry_resolved[commit_ptr] && !entry_committed[commit_ptr];
  assign commit_next  = commit_ptr + PTR_W'(retire_ok);

  // Per-entry decode of resolve and retire, plus the count of entries that
  // remain committed (and not popped) after this edge, which a flush keeps.
  always_comb begin
    resolve_hit = '0;
    retire_hit  = '0;
    survivors   = '0;
    for (int i = 0; i < SQ_SZ; i++) begin
      resolve_hit[i] = sq_packet.valid && resolving_sq_mask[i] && entry_valid[i];
      retire_hit[i]  = retire_ok && (commit_ptr == PTR_W'(i));
      if (entry_valid[i] && (entry_committed[i] || retire_hit[i]) &&
          !(pop && (head == PTR_W'(i))))
        survivors = survivors + CNT_W'(1);
    end
  end

  // Entry status bits: resolve, retire, alloc, then flush and pop, with the
  // later updates taking priority on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_valid     <= '0;
      entry_resolved  <= '0;
      entry_committed <= '0;
    end else begin
      for (int i = 0; i < SQ_SZ; i++) begin
        if (resolve_hit[i])
          entry_resolved[i] <= 1'b1;
        if (retire_hit[i])
          entry_committed[i] <= 1'b1;
        if (alloc_accept && !flush && (tail == PTR_W'(i))) begin
          entry_valid[i]     <= 1'b1;
          entry_resolved[i]  <= 1'b0;
          entry_committed[i] <= 1'b0;
        end
        if (flush && entry_valid[i] && !(entry_committed[i] || retire_hit[i])) begin
          entry_valid[i]    <= 1'b0;
          entry_resolved[i] <= 1'b0;
        end
        if (pop && (head == PTR_W'(i))) begin
          entry_valid[i]     <= 1'b0;
          entry_resolved[i]  <= 1'b0;
          entry_committed[i] <= 1'b0;
        end
      end
    end
  end

  // Payload capture from the address stage; payload needs no reset because
  // it is only observed behind the status bits.
  always_ff @(posedge clock) begin
    for (int i = 0; i < SQ_SZ; i++) begin
      if (resolve_hit[i]) begin
        entry_word_addr[i] <= sq_packet.addr[31:2];
        entry_result[i]    <= sq_packet.result;
        entry_byte_mask[i] <= sq_packet.byte_mask;
      end
    end
  end

  // Pointers and occupancy; on flush the tail snaps back to the commit point
  // and the count becomes the number of surviving committed entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      commit_ptr <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      head       <= head + PTR_W'(pop);
      commit_ptr <= commit_next;
      if (flush) begin
        tail  <= commit_next;
        count <= survivors;
      end else begin
        tail  <= tail + PTR_W'(alloc_accept);
        count <= count + CNT_W'(alloc_accept) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: reset state, single store drain, full
// queue, back-pressure, flush interactions and pointer wrap-around.

module tb_store_queue;
  import store_queue_pkg::*;

  localparam int SQ_SZ = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic [SQ_SZ-1:0]  sq_alloc_mask;
  logic              sq_full;
  logic              sq_empty;
  STORE_QUEUE_PACKET sq_packet;
  logic [SQ_SZ-1:0]  resolving_sq_mask;
  logic [SQ_SZ-1:0]  resolved_mask;
  logic              store_retire;
  logic              flush;

  int vectors     = 0;
  int miscompares = 0;

  store_queue_if mem_bus ();

  store_queue #(.SQ_SZ(SQ_SZ)) dut (
    .clock             (clock),
    .reset             (reset),
    .alloc_valid       (alloc_valid),
    .sq_alloc_mask     (sq_alloc_mask),
    .sq_full           (sq_full),
    .sq_empty          (sq_empty),
    .sq_packet         (sq_packet),
    .resolving_sq_mask (resolving_sq_mask),
    .resolved_mask     (resolved_mask),
    .store_retire      (store_retire),
    .flush             (flush),
    .mem               (mem_bus.master)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1;
    reset                 = 1'b0;
    alloc_valid           = 1'b0;
    store_retire          = 1'b0;
    flush                 = 1'b0;
    sq_packet             = '0;
    resolving_sq_mask     = '0;
    mem_bus.mem_req_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    applyStimulus();
  endtask

  task automatic alloc_n(input int n);
    for (int k = 0; k < n; k++) begin
      alloc_valid = 1'b1;
      applyStimulus();
    end
  endtask

  task automatic retire_n(input int n);
    for (int k = 0; k < n; k++) begin
      store_retire = 1'b1;
      applyStimulus();
    end
  endtask

  task automatic resolve_entry(input int slot, input logic [31:0] addr,
                               input logic [31:0] result, input logic [3:0] bmask);
    sq_packet.valid        = 1'b1;
    sq_packet.addr         = addr;
    sq_packet.result       = result;
    sq_packet.byte_mask    = bmask;
    sq_packet.dest_reg_idx = 5'(slot);
    resolving_sq_mask      = 8'b1 << slot;
    applyStimulus();
  endtask

  initial begin
    int base;
    int k;
    reset                 = 1'b1;
    alloc_valid           = 1'b0;
    store_retire          = 1'b0;
    flush                 = 1'b0;
    sq_packet             = '0;
    resolving_sq_mask     = '0;
    mem_bus.mem_req_ready = 1'b0;
    $display("[TB] start");

    do_reset();
    checkOutput("rst_empty", 32'(sq_empty), 32'd1);
    checkOutput("rst_full", 32'(sq_full), 32'd0);
    checkOutput("rst_alloc_mask", 32'(sq_alloc_mask), 32'h01);
    checkOutput("rst_resolved_mask", 32'(resolved_mask), 32'h00);
    checkOutput("rst_mem_valid", 32'(mem_bus.mem_req_valid), 32'd0);

    // Single store: alloc, resolve, retire, drain.
    alloc_n(1);
    checkOutput("s1_empty_after_alloc", 32'(sq_empty), 32'd0);
    resolve_entry(0, 32'h0000_1002, 32'h00AB_0000, 4'h4);
    checkOutput("s1_resolved_mask", 32'(resolved_mask), 32'h01);
    checkOutput("s1_valid_before_retire", 32'(mem_bus.mem_req_valid), 32'd0);
    retire_n(1);
    checkOutput("s1_mem_valid", 32'(mem_bus.mem_req_valid), 32'd1);
    checkOutput("s1_mem_addr", mem_bus.mem_req_addr, 32'h0000_1000);
    checkOutput("s1_mem_data", mem_bus.mem_req_data, 32'h00AB_0000);
    checkOutput("s1_mem_mask", 32'(mem_bus.mem_req_byte_mask), 32'h4);
    mem_bus.mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("s1_empty_after_pop", 32'(sq_empty), 32'd1);
    checkOutput("s1_valid_after_pop", 32'(mem_bus.mem_req_valid), 32'd0);

    // Fill to full, overflow alloc ignored, alloc with pop still ignored.
    do_reset();
    alloc_n(8);
    checkOutput("s2_full", 32'(sq_full), 32'd1);
    checkOutput("s2_alloc_mask", 32'(sq_alloc_mask), 32'h01);
    alloc_n(1);
    checkOutput("s2_count_after_9th", 32'(dut.count), 32'd8);
    checkOutput("s2_tail_after_9th", 32'(dut.tail), 32'd0);
    resolve_entry(0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    retire_n(1);
    checkOutput("s2_head_ready", 32'(mem_bus.mem_req_valid), 32'd1);
    alloc_valid           = 1'b1;
    mem_bus.mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("s2_count_pop_alloc", 32'(dut.count), 32'd7);
    checkOutput("s2_full_after_pop", 32'(sq_full), 32'd0);
    checkOutput("s2_alloc_mask_after_pop", 32'(sq_alloc_mask), 32'h01);

    // Back-pressure: request held stable for 5 cycles without ready.
    resolve_entry(1, 32'h0000_2004, 32'h1122_3344, 4'hF);
    retire_n(1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("s3_hold_valid", 32'(mem_bus.mem_req_valid), 32'd1);
      checkOutput("s3_hold_addr", mem_bus.mem_req_addr, 32'h0000_2004);
      checkOutput("s3_hold_data", mem_bus.mem_req_data, 32'h1122_3344);
      applyStimulus();
    end
    mem_bus.mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("s3_head_after_pop", 32'(dut.head), 32'd2);
    checkOutput("s3_count_after_pop", 32'(dut.count), 32'd6);
    checkOutput("s3_valid_after_pop", 32'(mem_bus.mem_req_valid), 32'd0);

    // Flush with two committed of four allocated.
    do_reset();
    alloc_n(4);
    for (int j = 0; j < 4; j++)
      resolve_entry(j, 32'h0000_3000 + 32'(4 * j), 32'hA000_0000 + 32'(j), 4'hF);
    checkOutput("s4_resolved_before", 32'(resolved_mask), 32'h0F);
    retire_n(2);
    flush = 1'b1;
    applyStimulus();
    checkOutput("s4_count", 32'(dut.count), 32'd2);
    checkOutput("s4_tail", 32'(dut.tail), 32'd2);
    checkOutput("s4_resolved_after", 32'(resolved_mask), 32'h03);
    checkOutput("s4_alloc_mask", 32'(sq_alloc_mask), 32'h04);
    mem_bus.mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("s4_second_addr", mem_bus.mem_req_addr, 32'h0000_3004);
    checkOutput("s4_second_data", mem_bus.mem_req_data, 32'hA000_0001);
    mem_bus.mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("s4_empty", 32'(sq_empty), 32'd1);

    // Flush together with retire and alloc on the same edge.
    do_reset();
    alloc_n(3);
    resolve_entry(0, 32'h0000_5000, 32'hB000_0000, 4'h3);
    resolve_entry(1, 32'h0000_5004, 32'hB000_0001, 4'hC);
    retire_n(1);
    store_retire = 1'b1;
    alloc_valid  = 1'b1;
    flush        = 1'b1;
    applyStimulus();
    checkOutput("s5_count", 32'(dut.count), 32'd2);
    checkOutput("s5_tail", 32'(dut.tail), 32'd2);
    checkOutput("s5_resolved", 32'(resolved_mask), 32'h03);
    checkOutput("s5_alloc_mask", 32'(sq_alloc_mask), 32'h04);
    checkOutput("s5_first_data", mem_bus.mem_req_data, 32'hB000_0000);
    mem_bus.mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("s5_kept_valid", 32'(mem_bus.mem_req_valid), 32'd1);
    checkOutput("s5_kept_addr", mem_bus.mem_req_addr, 32'h0000_5004);
    checkOutput("s5_kept_mask", 32'(mem_bus.mem_req_byte_mask), 32'hC);
    mem_bus.mem_req_ready = 1'b1;
    applyStimulus();
    checkOutput("s5_empty", 32'(sq_empty), 32'd1);

    // Wrap-around: 20 stores in batches of 4, drained in FIFO order.
    base = 2;
    for (int b = 0; b < 5; b++) begin
      alloc_n(4);
      for (int j = 0; j < 4; j++) begin
        k = 4 * b + j;
        resolve_entry((base + j) % SQ_SZ, 32'h0000_4001 + 32'(4 * k),
                      32'hC0DE_0000 + 32'(k), 4'(1 << (k % 4)));
      end
      retire_n(4);
      for (int j = 0; j < 4; j++) begin
        k = 4 * b + j;
        checkOutput("wrap_valid", 32'(mem_bus.mem_req_valid), 32'd1);
        checkOutput("wrap_addr", mem_bus.mem_req_addr, 32'h0000_4000 + 32'(4 * k));
        checkOutput("wrap_data", mem_bus.mem_req_data, 32'hC0DE_0000 + 32'(k));
        checkOutput("wrap_mask", 32'(mem_bus.mem_req_byte_mask), 32'(1 << (k % 4)));
        mem_bus.mem_req_ready = 1'b1;
        applyStimulus();
      end
      base = (base + 4) % SQ_SZ;
      checkOutput("wrap_head", 32'(dut.head), 32'(base));
    end
    checkOutput("wrap_tail", 32'(dut.tail), 32'd6);
    checkOutput("wrap_empty", 32'(sq_empty), 32'd1);

    // Reset overrides a pending drain.
    alloc_n(1);
    resolve_entry(6, 32'h0000_6000, 32'hFFFF_0000, 4'hF);
    retire_n(1);
    checkOutput("rst2_pre_valid", 32'(mem_bus.mem_req_valid), 32'd1);
    reset                 = 1'b1;
    mem_bus.mem_req_ready = 1'b1;
    alloc_valid           = 1'b1;
    applyStimulus();
    checkOutput("rst2_empty", 32'(sq_empty), 32'd1);
    checkOutput("rst2_valid", 32'(mem_bus.mem_req_valid), 32'd0);
    checkOutput("rst2_alloc_mask", 32'(sq_alloc_mask), 32'h01);
    checkOutput("rst2_head", 32'(dut.head), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter SQ_SZ, default 8, number of entries (power of two, >=2).
REQ-002 SHALL have ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- alloc_valid  in  1  dispatch requests one store entry this cycle.
- sq_alloc_mask  out  SQ_SZ  one-hot mask of the entry the next allocation receives (tail).
- sq_full  out  1  no free entry.
- sq_empty  out  1  no occupied entry.
- sq_packet  in  STORE_QUEUE_PACKET  resolved store from store address stage: valid, addr[31:0], result[31:0] (pre-shifted data), byte_mask[3:0], dest_reg_idx.
- resolving_sq_mask  in  SQ_SZ  one-hot entry being resolved by sq_packet.
- resolved_mask  out  SQ_SZ  per-entry "address/data resolved" bits, for load dependence checks.
- store_retire  in  1  ROB commits the oldest uncommitted store.
- flush  in  1  mispredict; discard all uncommitted entries.
- mem_req_valid  out  1  drain request to data memory.
- mem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_req_data  out  32  sq entry result.
- mem_req_byte_mask  out  4  sq entry byte_mask.
- mem_req_ready  in  1  memory accepts request this cycle.

Function
REQ-003 SHALL hold a circular buffer of SQ_SZ entries, each: valid, resolved, committed, addr, result, byte_mask.
REQ-004 SHALL keep head (oldest), commit (oldest uncommitted), tail (next free) pointers, each log2(SQ_SZ) bits, wrapping SQ_SZ-1 -> 0, plus count 0..SQ_SZ.
REQ-005 sq_full SHALL equal (count==SQ_SZ); sq_empty SHALL equal (count==0); both from registered state only.
REQ-006 Allocation: alloc_valid && !sq_full SHALL set entry[tail].valid, clear resolved/committed, advance tail; alloc_valid while sq_full SHALL be ignored (no bypass of same-cycle pop).
REQ-007 sq_alloc_mask SHALL be one-hot of tail, valid even when full.
REQ-008 Resolve: sq_packet.valid SHALL write addr/result/byte_mask into the entry selected by resolving_sq_mask and set resolved at the next edge; ignored if that entry is not valid.
REQ-009 resolved_mask bit i SHALL equal entry[i].valid && entry[i].resolved (registered).
REQ-010 Retire: store_retire SHALL set committed on entry[commit] and advance commit; retire of an unresolved or invalid entry is an illegal input (bench assertion), no state change.
REQ-011 Drain: mem_req_valid SHALL be 1 iff entry[head].valid && committed && resolved; mem_req_* SHALL be driven combinationally from entry[head].
REQ-012 On mem_req_valid && mem_req_ready the head entry SHALL be cleared and head advanced; request fields SHALL remain stable while valid && !ready.
REQ-013 Latency: a store resolved and retired in cycle N SHALL raise mem_req_valid in cycle N+1 (earliest); one pop per cycle maximum.
REQ-014 Flush: SHALL clear every valid entry not committed, set tail = commit, recompute count = committed entries.
REQ-015 Simultaneous events, same edge:
- retire + flush: retire applied first; newly committed entry survives.
- alloc + flush: flush wins, alloc dropped.
- resolve + flush: resolve to an uncommitted entry discarded.
- pop + flush: pop completes.
- alloc + pop: count unchanged, both pointers advance.
- resolve + retire of same entry: not legal (retire requires prior resolve).
REQ-016 count SHALL update as count + alloc_accepted - pop, then flush override per REQ-014.

Reset
REQ-017 On reset SHALL clear all entry valid/resolved/committed bits and set head=commit=tail=0, count=0.
REQ-018 After reset: sq_empty=1, sq_full=0, sq_alloc_mask=one-hot bit 0, resolved_mask=0, mem_req_valid=0; reset SHALL override all same-cycle inputs including mid-drain requests.

Verification
REQ-019 Bench SHALL cover:
- Reset, alloc 1, resolve mask 0x01 with addr 0x1002, result 0x00AB0000, byte_mask 0x4, retire -> next cycle mem_req_valid=1, addr 0x1000, data 0x00AB0000, mask 0x4; ready=1 -> sq_empty=1.
- Alloc 8 with no pop -> sq_full=1, alloc_mask=0x01; 9th alloc ignored; pop with alloc same cycle -> alloc still ignored, count 7.
- mem_req_ready held 0 for 5 cycles -> mem_req_* stable and valid throughout; head pops on first ready cycle.
- 4 entries allocated, 2 retired, flush -> count 2, tail=2, resolved_mask bits 2,3 cleared; next alloc_mask=0x04.
- Flush with simultaneous retire and alloc -> retired entry kept, alloc dropped.
- Wrap-around: 20 alloc/resolve/retire/drain sequences -> pointers wrap 7->0, FIFO order preserved at memory.
